// File: rtl/mshr_entry_table_if.sv
// Signal bundle between the MSHR entry table (slave) and its neighbours: the entry
// pre-allocator, the miss requester, the refill issue stage and the release path.
interface mshr_entry_table_if #(
    parameter int ENTRY_NUM      = 32,
    parameter int ENTRY_ID_WIDTH = $clog2(ENTRY_NUM),
    parameter int ADDR_WIDTH     = 40,
    parameter int TXN_ID_WIDTH   = 8
);
    logic [ENTRY_NUM-1:0]      v_free_vld;
    logic [ENTRY_NUM-1:0]      v_free_rdy;
    logic                      idx_vld;
    logic                      idx_rdy;
    logic [ENTRY_ID_WIDTH-1:0] idx;
    logic                      req_vld;
    logic                      req_rdy;
    logic [ADDR_WIDTH-1:0]     req_addr;
    logic [TXN_ID_WIDTH-1:0]   req_txn_id;
    logic                      out_vld;
    logic                      out_rdy;
    logic [ENTRY_ID_WIDTH-1:0] out_index;
    logic [ADDR_WIDTH-1:0]     out_addr;
    logic [TXN_ID_WIDTH-1:0]   out_txn_id;
    logic                      rel_vld;
    logic [ENTRY_ID_WIDTH-1:0] rel_index;
    logic                      rel_err;
    logic [ENTRY_ID_WIDTH:0]   occ_cnt;

    modport slave (
        output v_free_vld, idx_rdy, req_rdy, out_vld, out_index, out_addr, out_txn_id,
               rel_err, occ_cnt,
        input  v_free_rdy, idx_vld, idx, req_vld, req_addr, req_txn_id, out_rdy,
               rel_vld, rel_index
    );

    modport master (
        input  v_free_vld, idx_rdy, req_rdy, out_vld, out_index, out_addr, out_txn_id,
               rel_err, occ_cnt,
        output v_free_rdy, idx_vld, idx, req_vld, req_addr, req_txn_id, out_rdy,
               rel_vld, rel_index
    );
endinterface

// File: rtl/mshr_entry_table.sv
// MSHR per-entry status table: FREE -> RSVD (pre-allocator grant) -> ALLOC (join) -> FREE (release).
// Define MSHR_TABLE_OCC_EN to enable the registered occupancy counter on occ_cnt.
module mshr_entry_table #(
    parameter int ENTRY_NUM         = 32,
    parameter int ENTRY_ID_WIDTH    = $clog2(ENTRY_NUM),
    parameter int ADDR_WIDTH        = 40,
    parameter int LINE_OFFSET_WIDTH = 6,
    parameter int TXN_ID_WIDTH      = 8
) (
    input logic                clk,
    input logic                rst_n,
    mshr_entry_table_if.slave  bus
);
    localparam int LINE_WIDTH = ADDR_WIDTH - LINE_OFFSET_WIDTH;
    localparam int CNT_WIDTH  = ENTRY_ID_WIDTH + 1;

    typedef enum logic [1:0] {
        ST_FREE  = 2'd0,
        ST_RSVD  = 2'd1,
        ST_ALLOC = 2'd2
    } entry_state_e;

    entry_state_e            state_q [ENTRY_NUM];
    entry_state_e            state_d [ENTRY_NUM];
    logic [LINE_WIDTH-1:0]   line_q  [ENTRY_NUM];

    logic [ENTRY_NUM-1:0]    free_vec;
    logic [ENTRY_NUM-1:0]    grant_vec;
    logic [ENTRY_NUM-1:0]    match_vec;
    logic [ENTRY_NUM-1:0]    join_hit;
    logic [ENTRY_NUM-1:0]    rel_hit;
    logic [LINE_WIDTH-1:0]   req_line;
    logic                    conflict;
    logic                    can_load;
    logic                    fire;
    logic                    rel_ok;

    logic                      out_vld_q;
    logic [ENTRY_ID_WIDTH-1:0] out_index_q;
    logic [LINE_WIDTH-1:0]     out_line_q;
    logic [TXN_ID_WIDTH-1:0]   out_txn_q;

    logic unused_offset;
    assign unused_offset = ^bus.req_addr[LINE_OFFSET_WIDTH-1:0];

    assign req_line = bus.req_addr[ADDR_WIDTH-1:LINE_OFFSET_WIDTH];

    // NOTE: every vector written here gets a full default first so no latch can be inferred.
    always_comb begin
        free_vec  = '0;
        match_vec = '0;
        join_hit  = '0;
        rel_hit   = '0;
        for (int i = 0; i < ENTRY_NUM; i++) begin
            free_vec[i]  = (state_q[i] == ST_FREE);
            match_vec[i] = (state_q[i] == ST_ALLOC) && (line_q[i] == req_line);
            join_hit[i]  = (bus.idx == ENTRY_ID_WIDTH'(i));
            rel_hit[i]   = bus.rel_vld && (bus.rel_index == ENTRY_ID_WIDTH'(i))
                           && (state_q[i] == ST_ALLOC);
        end
        grant_vec = bus.v_free_rdy & free_vec;
    end

    // Conflict is taken from pre-release state, so a same-cycle release still stalls the request.
    assign conflict = |match_vec;
    assign can_load = !out_vld_q || bus.out_rdy;
    assign fire     = bus.req_vld && bus.idx_vld && can_load && !conflict;
    assign rel_ok   = |rel_hit;

    always_comb begin
        for (int i = 0; i < ENTRY_NUM; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                ST_FREE:  if (grant_vec[i])          state_d[i] = ST_RSVD;
                ST_RSVD:  if (fire && join_hit[i])   state_d[i] = ST_ALLOC;
                ST_ALLOC: if (rel_hit[i])            state_d[i] = ST_FREE;
                default:                             state_d[i] = ST_FREE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRY_NUM; i++) begin
                state_q[i] <= ST_FREE;
            end
        end else begin
            for (int i = 0; i < ENTRY_NUM; i++) begin
                state_q[i] <= state_d[i];
            end
        end
    end

    // NOTE: line addresses are not reset; they are only compared while their entry is ALLOC.
    always_ff @(posedge clk) begin
        for (int i = 0; i < ENTRY_NUM; i++) begin
            if (fire && join_hit[i] && (state_q[i] == ST_RSVD)) begin
                line_q[i] <= req_line;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld_q   <= 1'b0;
            out_index_q <= '0;
            out_line_q  <= '0;
            out_txn_q   <= '0;
        end else if (fire) begin
            out_vld_q   <= 1'b1;
            out_index_q <= bus.idx;
            out_line_q  <= req_line;
            out_txn_q   <= bus.req_txn_id;
        end else if (bus.out_rdy) begin
            out_vld_q   <= 1'b0;
        end
    end

`ifdef MSHR_TABLE_OCC_EN
    logic [CNT_WIDTH-1:0] occ_q;
    logic [CNT_WIDTH-1:0] occ_d;
    logic [CNT_WIDTH-1:0] grant_cnt;

    always_comb begin
        grant_cnt = '0;
        for (int i = 0; i < ENTRY_NUM; i++) begin
            grant_cnt = grant_cnt + CNT_WIDTH'(grant_vec[i]);
        end
        occ_d = occ_q + grant_cnt - CNT_WIDTH'(rel_ok);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign bus.occ_cnt = occ_q;
`else
    assign bus.occ_cnt = '0;
`endif

    assign bus.v_free_vld = free_vec;
    assign bus.req_rdy    = fire;
    assign bus.idx_rdy    = fire;
    assign bus.out_vld    = out_vld_q;
    assign bus.out_index  = out_index_q;
    assign bus.out_addr   = {out_line_q, {LINE_OFFSET_WIDTH{1'b0}}};
    assign bus.out_txn_id = out_txn_q;
    assign bus.rel_err    = bus.rel_vld && !rel_ok;
endmodule

// File: tb/tb_mshr_entry_table.sv
// Directed bench for mshr_entry_table: a per-entry array model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_mshr_entry_table;
    localparam int M_FREE  = 0;
    localparam int M_RSVD  = 1;
    localparam int M_ALLOC = 2;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    mshr_entry_table_if bus ();

    mshr_entry_table dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: what each entry is, its line, and the content of the output slot.
    int          m_state [32];
    logic [33:0] m_line  [32];
    logic        m_out_vld;
    logic [4:0]  m_out_index;
    logic [39:0] m_out_addr;
    logic [7:0]  m_out_txn;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_free();
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < 32; i++) v[i] = (m_state[i] == M_FREE);
        return v;
    endfunction

    function automatic logic exp_conflict();
        for (int i = 0; i < 32; i++)
            if (m_state[i] == M_ALLOC && m_line[i] == bus.req_addr[39:6]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic exp_fire();
        return bus.req_vld && bus.idx_vld && (!m_out_vld || bus.out_rdy) && !exp_conflict();
    endfunction

    function automatic logic exp_rel_err();
        return bus.rel_vld && (m_state[bus.rel_index] != M_ALLOC);
    endfunction

    function automatic logic [5:0] exp_occ();
        int n;
        n = 0;
`ifdef MSHR_TABLE_OCC_EN
        for (int i = 0; i < 32; i++) if (m_state[i] != M_FREE) n++;
`endif
        return 6'(n);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) m_state[i] <= M_FREE;
            m_out_vld   <= 1'b0;
            m_out_index <= '0;
            m_out_addr  <= '0;
            m_out_txn   <= '0;
        end else begin
            for (int i = 0; i < 32; i++) begin
                if (m_state[i] == M_FREE && bus.v_free_rdy[i]) m_state[i] <= M_RSVD;
                if (m_state[i] == M_ALLOC && bus.rel_vld && bus.rel_index == 5'(i))
                    m_state[i] <= M_FREE;
            end
            if (exp_fire()) begin
                check("join_idx_rsvd", 64'(m_state[bus.idx]), 64'(M_RSVD));
                if (m_state[bus.idx] == M_RSVD) begin
                    m_state[bus.idx] <= M_ALLOC;
                    m_line[bus.idx]  <= bus.req_addr[39:6];
                end
                m_out_vld   <= 1'b1;
                m_out_index <= bus.idx;
                m_out_addr  <= {bus.req_addr[39:6], 6'b0};
                m_out_txn   <= bus.req_txn_id;
            end else if (bus.out_rdy) begin
                m_out_vld <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_free", 64'(bus.v_free_vld), 64'hFFFF_FFFF);
            check("rst_out_vld", 64'(bus.out_vld), 64'd0);
            check("rst_occ", 64'(bus.occ_cnt), 64'd0);
        end else begin
            check("cyc_free", 64'(bus.v_free_vld), 64'(exp_free()));
            check("cyc_req_rdy", 64'(bus.req_rdy), 64'(exp_fire()));
            check("cyc_idx_rdy", 64'(bus.idx_rdy), 64'(exp_fire()));
            check("cyc_out_vld", 64'(bus.out_vld), 64'(m_out_vld));
            check("cyc_out_index", 64'(bus.out_index), 64'(m_out_index));
            check("cyc_out_addr", 64'(bus.out_addr), 64'(m_out_addr));
            check("cyc_out_txn", 64'(bus.out_txn_id), 64'(m_out_txn));
            check("cyc_rel_err", 64'(bus.rel_err), 64'(exp_rel_err()));
            check("cyc_occ", 64'(bus.occ_cnt), 64'(exp_occ()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic join_req(input logic [4:0] i, input logic [39:0] a, input logic [7:0] t);
        int n;
        bus.idx        = i;
        bus.req_addr   = a;
        bus.req_txn_id = t;
        bus.req_vld    = 1'b1;
        bus.idx_vld    = 1'b1;
        n = 0;
        #2;
        while (!exp_fire() && n < 20) begin
            tick();
            #2;
            n++;
        end
        if (!exp_fire()) check("join_timeout", 64'(exp_fire()), 64'd1);
        tick();
        bus.req_vld = 1'b0;
        bus.idx_vld = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.v_free_rdy = '0;
        bus.idx_vld = 1'b0;
        bus.idx = '0;
        bus.req_vld = 1'b0;
        bus.req_addr = '0;
        bus.req_txn_id = '0;
        bus.out_rdy = 1'b1;
        bus.rel_vld = 1'b0;
        bus.rel_index = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #2;
        check("init_free", 64'(bus.v_free_vld), 64'hFFFF_FFFF);
        check("init_out_vld", 64'(bus.out_vld), 64'd0);

        // 1: grant entry 0, then join request 0x12345 / txn 7.
        bus.v_free_rdy = 32'h1;
        tick();
        bus.v_free_rdy = '0;
        bus.idx = 5'd0; bus.idx_vld = 1'b1;
        bus.req_addr = 40'h12345; bus.req_txn_id = 8'd7; bus.req_vld = 1'b1;
        #2;
        check("t1_free0_rsvd", 64'(bus.v_free_vld[0]), 64'd0);
        check("t1_req_rdy", 64'(bus.req_rdy), 64'd1);
        tick();
        bus.req_vld = 1'b0; bus.idx_vld = 1'b0;
        check("t1_out_vld", 64'(bus.out_vld), 64'd1);
        check("t1_out_index", 64'(bus.out_index), 64'd0);
        check("t1_out_addr", 64'(bus.out_addr), 64'h12340);
        check("t1_out_txn", 64'(bus.out_txn_id), 64'd7);

        // 2: same line as ALLOC entry 0 stalls until the release has taken effect.
        bus.v_free_rdy = 32'h2;
        tick();
        bus.v_free_rdy = '0;
        bus.idx = 5'd1; bus.idx_vld = 1'b1;
        bus.req_addr = 40'h12378; bus.req_txn_id = 8'd8; bus.req_vld = 1'b1;
        #2;
        check("t2_stall_a", 64'(bus.req_rdy), 64'd0);
        tick();
        #2;
        check("t2_stall_b", 64'(bus.req_rdy), 64'd0);
        tick();
        bus.rel_vld = 1'b1; bus.rel_index = 5'd0;
        #2;
        check("t2_stall_rel_cycle", 64'(bus.req_rdy), 64'd0);
        check("t2_rel_err", 64'(bus.rel_err), 64'd0);
        tick();
        bus.rel_vld = 1'b0;
        #2;
        check("t2_accept", 64'(bus.req_rdy), 64'd1);
        tick();
        bus.req_vld = 1'b0; bus.idx_vld = 1'b0;
        check("t2_out_index", 64'(bus.out_index), 64'd1);
        check("t2_out_addr", 64'(bus.out_addr), 64'h12340);
        check("t2_out_txn", 64'(bus.out_txn_id), 64'd8);

        // 3: back-pressure holds the output and stalls the next join.
        bus.v_free_rdy = 32'h4;
        tick();
        bus.v_free_rdy = 32'h8;
        tick();
        bus.v_free_rdy = '0;
        join_req(5'd2, 40'h2000, 8'd9);
        bus.out_rdy = 1'b0;
        bus.idx = 5'd3; bus.idx_vld = 1'b1;
        bus.req_addr = 40'h3000; bus.req_txn_id = 8'd10; bus.req_vld = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #2;
            check("t3_hold_vld", 64'(bus.out_vld), 64'd1);
            check("t3_hold_index", 64'(bus.out_index), 64'd2);
            check("t3_hold_addr", 64'(bus.out_addr), 64'h2000);
            check("t3_stall", 64'(bus.req_rdy), 64'd0);
            tick();
        end
        bus.out_rdy = 1'b1;
        #2;
        check("t3_accept", 64'(bus.req_rdy), 64'd1);
        tick();
        bus.req_vld = 1'b0; bus.idx_vld = 1'b0;
        check("t3_out_index", 64'(bus.out_index), 64'd3);
        check("t3_out_addr", 64'(bus.out_addr), 64'h3000);
        tick();
        check("t3_drained", 64'(bus.out_vld), 64'd0);

        // 4: bad releases; index 40 truncates to 8 on the 5-bit port, which is FREE.
        bus.rel_vld = 1'b1; bus.rel_index = 5'd5;
        #2;
        check("t4_err_free", 64'(bus.rel_err), 64'd1);
        tick();
        bus.rel_vld = 1'b0;
        #2;
        check("t4_err_clear", 64'(bus.rel_err), 64'd0);
        check("t4_free_same", 64'(bus.v_free_vld), 64'hFFFF_FFF1);
        bus.rel_vld = 1'b1; bus.rel_index = 5'(40);
        #2;
        check("t4_err_range", 64'(bus.rel_err), 64'd1);
        tick();
        bus.rel_vld = 1'b0;

        // 5: fill the table, then release/re-grant at the top.
        for (int i = 0; i < 32; i++) begin
            if (m_state[i] == M_FREE) begin
                bus.v_free_rdy = 32'h1 << i;
                tick();
            end
        end
        bus.v_free_rdy = '0;
        for (int i = 0; i < 32; i++) begin
            if (m_state[i] == M_RSVD) join_req(5'(i), 40'h10_0000 + 40'(i) * 40'd64, 8'(i));
        end
        tick();
        check("t5_full_free", 64'(bus.v_free_vld), 64'd0);
`ifdef MSHR_TABLE_OCC_EN
        check("t5_occ_full", 64'(bus.occ_cnt), 64'd32);
`else
        check("t5_occ_tied", 64'(bus.occ_cnt), 64'd0);
`endif
        bus.rel_vld = 1'b1; bus.rel_index = 5'd31;
        tick();
        bus.rel_vld = 1'b0;
        bus.v_free_rdy = 32'h8000_0000;
        #2;
        check("t5_free31", 64'(bus.v_free_vld), 64'h8000_0000);
`ifdef MSHR_TABLE_OCC_EN
        check("t5_occ_31", 64'(bus.occ_cnt), 64'd31);
`endif
        tick();
        bus.v_free_rdy = '0;
`ifdef MSHR_TABLE_OCC_EN
        check("t5_occ_32", 64'(bus.occ_cnt), 64'd32);
`endif
        bus.rel_vld = 1'b1; bus.rel_index = 5'd30;
        tick();
        bus.rel_index = 5'd28; bus.v_free_rdy = 32'h4000_0000;
        tick();
        bus.rel_vld = 1'b0; bus.v_free_rdy = '0;
        check("t5_swap_free", 64'(bus.v_free_vld), 64'h1000_0000);
`ifdef MSHR_TABLE_OCC_EN
        check("t5_occ_net0", 64'(bus.occ_cnt), 64'd31);
`endif

        // 6: asynchronous reset with a held output and a full table.
        bus.v_free_rdy = 32'h1000_0000;
        tick();
        bus.v_free_rdy = '0;
        bus.out_rdy = 1'b0;
        join_req(5'd28, 40'h5000, 8'h55);
        check("t6_out_held", 64'(bus.out_vld), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        check("t6_rst_out_vld", 64'(bus.out_vld), 64'd0);
        check("t6_rst_free", 64'(bus.v_free_vld), 64'hFFFF_FFFF);
        check("t6_rst_occ", 64'(bus.occ_cnt), 64'd0);
        check("t6_rst_addr", 64'(bus.out_addr), 64'd0);
        check("t6_rst_rel_err", 64'(bus.rel_err), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        bus.out_rdy = 1'b1;
        bus.v_free_rdy = 32'h1;
        tick();
        bus.v_free_rdy = '0;
        join_req(5'd0, 40'h12345, 8'd7);
        check("t6_recover_addr", 64'(bus.out_addr), 64'h12340);
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
